// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared CPU-side types: the 32-bit word and the RAM status encoding
//   reported by the RAM model/adapter.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage : cpu_types_pkg

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
//   Arbiter FSM state type, default parameter values and the round-robin
//   pointer advance helper shared by the arbiter files.
package ram_port_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_t;

   localparam int DEF_NREQ      = 4;
   localparam int DEF_MAX_BURST = 2;
   localparam int DEF_TIMEOUT   = 64;

   // Index following idx in a ring of n entries.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
   endfunction

endpackage : ram_port_arbiter_pkg

// File: rtl/ram_port_arbiter_rr_pick.sv
// ram_port_arbiter_rr_pick (module rr_pick)
//   Combinational round-robin picker: scans req_i starting at ptr_i and
//   wrapping, returning the first active index.
//   Ports:
//     req_i   [NREQ-1:0]  active request vector
//     ptr_i   [IW-1:0]    index with highest priority this round
//     found_o             at least one request is active
//     idx_o   [IW-1:0]    selected requester
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic            found_o,
   output logic [IW-1:0]   idx_o
);

   localparam int SW = IW + 1;

   // Priority scan from ptr_i upward, wrapping modulo NREQ.
   always_comb begin
      logic [SW-1:0] sum_v;
      logic [IW-1:0] cand_v;
      found_o = 1'b0;
      idx_o   = '0;
      sum_v   = '0;
      cand_v  = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum_v  = {1'b0, ptr_i} + SW'(k);
         // ptr_i < NREQ and k < NREQ, so one subtraction is enough to wrap
         sum_v  = (sum_v >= SW'(NREQ)) ? (sum_v - SW'(NREQ)) : sum_v;
         cand_v = sum_v[IW-1:0];
         if (!found_o && req_i[cand_v]) begin
            found_o = 1'b1;
            idx_o   = cand_v;
         end else begin
            found_o = found_o;
         end
      end
   end

endmodule : rr_pick

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Round-robin arbiter sharing one RAM port among NREQ word requesters.
//   A grant is taken in IDLE (one cycle of arbitration latency) and held in
//   OWN until the RAM reports ACCESS, the owner withdraws, or the watchdog
//   expires. req_lock lets the owner keep the port for up to MAX_BURST
//   consecutive words.
//   Ports:
//     CLK, RST                  clock, asynchronous active-high reset
//     req_ren/req_wen/req_lock  per-requester read/write/lock
//     req_addr/req_store        per-requester address and write data
//     req_wait                  active-low completion, per requester
//     req_load                  broadcast RAM read data
//     ramstate/ramload          RAM status and read data
//     ramREN/ramWEN/ramaddr/ramstore  RAM command, driven by the owner
//     grant_valid/grant_id      current ownership
//     timeout_err               one-cycle pulse on watchdog release
module ram_port_arbiter
   import cpu_types_pkg::*;
   import ram_port_arbiter_pkg::*;
#(
   parameter int NREQ      = DEF_NREQ,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int TIMEOUT   = DEF_TIMEOUT,
   parameter int IW        = $clog2(NREQ)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NREQ-1:0]      req_ren,
   input  logic [NREQ-1:0]      req_wen,
   input  logic [NREQ-1:0]      req_lock,
   input  word_t [NREQ-1:0]     req_addr,
   input  word_t [NREQ-1:0]     req_store,
   output logic [NREQ-1:0]      req_wait,
   output word_t                req_load,
   input  ramstate_t            ramstate,
   input  word_t                ramload,
   output logic                 ramREN,
   output logic                 ramWEN,
   output word_t                ramaddr,
   output word_t                ramstore,
   output logic                 grant_valid,
   output logic [IW-1:0]        grant_id,
   output logic                 timeout_err
);

   localparam int BW = $clog2(MAX_BURST) + 1;
   localparam int WW = $clog2(TIMEOUT) + 1;

   arb_state_t    state_q,     state_d;
   logic [IW-1:0] rr_ptr_q,    rr_ptr_d;
   logic [IW-1:0] grant_id_q,  grant_id_d;
   logic [BW-1:0] burst_cnt_q, burst_cnt_d;
   logic [WW-1:0] wd_cnt_q,    wd_cnt_d;

   logic [NREQ-1:0] req_any_s;
   logic            pick_found_s;
   logic [IW-1:0]   pick_idx_s;
   logic            own_ren_s, own_wen_s, own_lock_s;
   logic            active_s, access_s, wd_expire_s, lock_more_s;
   logic [IW-1:0]   ptr_after_s;

   assign req_any_s = req_ren | req_wen;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .req_i   (req_any_s),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found_s),
      .idx_o   (pick_idx_s)
   );

   // Owner-side decode of the current grant.
   always_comb begin
      own_ren_s   = req_ren[grant_id_q];
      own_wen_s   = req_wen[grant_id_q];
      own_lock_s  = req_lock[grant_id_q];
      active_s    = (state_q == OWN) && (own_ren_s || own_wen_s);
      access_s    = active_s && (ramstate == ACCESS);
      // ERROR and every other non-ACCESS status count toward the watchdog
      wd_expire_s = active_s && (ramstate != ACCESS) && (wd_cnt_q >= WW'(TIMEOUT - 1));
      lock_more_s = own_lock_s && ((32'(burst_cnt_q) + 32'd1) < 32'(MAX_BURST));
      ptr_after_s = IW'(rr_next(32'(grant_id_q), 32'(NREQ)));
   end

   // RAM command and completion outputs, driven only by an active owner.
   always_comb begin
      ramWEN   = active_s && own_wen_s;
      ramREN   = active_s && own_ren_s && !own_wen_s;
      ramaddr  = active_s ? req_addr[grant_id_q]  : 32'h0000_0000;
      ramstore = active_s ? req_store[grant_id_q] : 32'h0000_0000;
      req_wait = {NREQ{1'b1}};
      if (access_s) begin
         req_wait[grant_id_q] = 1'b0;
      end else begin
         req_wait = {NREQ{1'b1}};
      end
      req_load    = ramload;
      grant_valid = (state_q == OWN);
      grant_id    = grant_id_q;
      timeout_err = wd_expire_s;
   end

   // Next-state logic for grant ownership, burst and watchdog counters.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_id_d  = grant_id_q;
      burst_cnt_d = burst_cnt_q;
      wd_cnt_d    = wd_cnt_q;
      case (state_q)
         IDLE: begin
            burst_cnt_d = '0;
            wd_cnt_d    = '0;
            if (pick_found_s) begin
               grant_id_d = pick_idx_s;
               state_d    = OWN;
            end else begin
               state_d    = IDLE;
            end
         end
         OWN: begin
            if (!active_s || wd_expire_s || (access_s && !lock_more_s)) begin
               // withdrawal, watchdog expiry or final word of the grant
               state_d     = IDLE;
               rr_ptr_d    = ptr_after_s;
               burst_cnt_d = '0;
               wd_cnt_d    = '0;
            end else if (access_s) begin
               state_d     = OWN;
               wd_cnt_d    = '0;
               burst_cnt_d = (burst_cnt_q == '1) ? burst_cnt_q : (burst_cnt_q + BW'(1));
            end else begin
               state_d     = OWN;
               wd_cnt_d    = (wd_cnt_q == '1) ? wd_cnt_q : (wd_cnt_q + WW'(1));
            end
         end
         default: begin
            state_d     = IDLE;
            burst_cnt_d = '0;
            wd_cnt_d    = '0;
         end
      endcase
   end

   // Arbiter state registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_id_q  <= '0;
         burst_cnt_q <= '0;
         wd_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_id_q  <= grant_id_d;
         burst_cnt_q <= burst_cnt_d;
         wd_cnt_q    <= wd_cnt_d;
      end
   end

endmodule : ram_port_arbiter
